// File: rtl/clkdiv_ctrl.sv
// Programmable divide-by-N clock-enable generator with boundary-aligned divisor reconfiguration.
// Emits a one-cycle tick at the end of each period and a near-50% duty level output.
module clkdiv_ctrl #(
    parameter int          CNT_W   = 8,
    parameter int unsigned DEF_DIV = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic             div_tick_o,
    output logic             div_level_o,
    output logic             running_o,
    output logic [CNT_W-1:0] cur_div_o
);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             err_q, err_d;

    logic             active, accept, legal, tick;
    logic [CNT_W-1:0] last_cnt, hi_len;

    // Divisor >= 2 keeps these subtractions from wrapping.
    assign last_cnt = cur_div_q - CNT_W'(1);
    assign hi_len   = cur_div_q - (cur_div_q >> 1);

    assign active = (state_q != IDLE);
    assign tick   = active && (cnt_q == last_cnt);
    assign legal  = (cfg_div_i >= CNT_W'(2));
    assign accept = cfg_valid_i && cfg_ready_o;

    assign cfg_ready_o = (state_q != PEND);
    assign cfg_err_o   = err_q;
    assign div_tick_o  = tick;
    assign div_level_o = active && (cnt_q < hi_len);
    assign running_o   = active;
    assign cur_div_o   = cur_div_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        err_d      = accept && !legal;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept && legal) cur_div_d = cfg_div_i;
                if (en_i) state_d = RUN;
            end
            RUN: begin
                if (tick) begin
                    cnt_d = '0;
                    if (accept && legal) cur_div_d = cfg_div_i;
                    if (!en_i) state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (accept && legal) begin
                        pend_div_d = cfg_div_i;
                        state_d    = PEND;
                    end
                end
            end
            PEND: begin
                if (tick) begin
                    cnt_d      = '0;
                    cur_div_d  = pend_div_q;
                    pend_div_d = '0;
                    state_d    = en_i ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_div_q  <= CNT_W'(DEF_DIV);
            pend_div_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed scoreboard bench for clkdiv_ctrl: each step queues the expected outputs
// for the cycle after the next rising edge, then pops and compares them.
module tb_clkdiv_ctrl;

    logic       clk, rst, en, cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready, cfg_err, div_tick, div_level, running;
    logic [7:0] cur_div;

    int checks = 0;
    int errors = 0;

    // {tick, level, running, ready, err, cur_div}
    logic [12:0] exp_q[$];
    logic [12:0] got, want;

    logic [4:0] L5 = 5'b11100, T5 = 5'b00001;
    logic [6:0] L7 = 7'b1111000, T7 = 7'b0000001;
    logic [1:0] L2 = 2'b10, T2 = 2'b01;

    clkdiv_ctrl #(.CNT_W(8), .DEF_DIV(5)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .cfg_valid_i(cfg_valid), .cfg_div_i(cfg_div),
        .cfg_ready_o(cfg_ready), .cfg_err_o(cfg_err),
        .div_tick_o(div_tick), .div_level_o(div_level),
        .running_o(running), .cur_div_o(cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic e, input logic v, input logic [7:0] d, input logic r,
                       input string tag, input logic t, input logic l, input logic ru,
                       input logic rd, input logic er, input logic [7:0] cd);
        rst = r; en = e; cfg_valid = v; cfg_div = d;
        exp_q.push_back({t, l, ru, rd, er, cd});
        @(posedge clk);
        @(negedge clk);
        got  = {div_tick, div_level, running, cfg_ready, cfg_err, cur_div};
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed tick/lvl/run/rdy/err/div=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
                   tag, got[12], got[11], got[10], got[9], got[8], got[7:0],
                   want[12], want[11], want[10], want[9], want[8], want[7:0]);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
        @(negedge clk);

        cyc(0, 0, 0, 0, "reset",     0, 0, 0, 1, 0, 5);
        cyc(0, 0, 0, 1, "idle_hold", 0, 0, 0, 1, 0, 5);

        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 5; k++)
                cyc(1, 0, 0, 1, "n5_run", T5[4-k], L5[4-k], 1, 1, 0, 5);

        // illegal divisors while running
        cyc(1, 0, 0, 1, "ill_c0", 0, 1, 1, 1, 0, 5);
        cyc(1, 1, 1, 1, "ill_one", 0, 1, 1, 1, 1, 5);
        cyc(1, 1, 0, 1, "ill_zero", 0, 1, 1, 1, 1, 5);
        cyc(1, 0, 0, 1, "ill_c3", 0, 0, 1, 1, 0, 5);
        cyc(1, 0, 0, 1, "ill_c4", 1, 0, 1, 1, 0, 5);

        // divisor 7 offered at cnt=1, held pending until the tick
        cyc(1, 0, 0, 1, "pend_c0", 0, 1, 1, 1, 0, 5);
        cyc(1, 0, 0, 1, "pend_c1", 0, 1, 1, 1, 0, 5);
        cyc(1, 1, 7, 1, "pend_c2", 0, 1, 1, 0, 0, 5);
        cyc(1, 0, 0, 1, "pend_c3", 0, 0, 1, 0, 0, 5);
        cyc(1, 0, 0, 1, "pend_c4", 1, 0, 1, 0, 0, 5);
        for (int k = 0; k < 7; k++)
            cyc(1, 0, 0, 1, "n7_run", T7[6-k], L7[6-k], 1, 1, 0, 7);

        // accept on a tick cycle loads directly
        cyc(1, 1, 2, 1, "tickld_c0", 0, 1, 1, 1, 0, 2);
        cyc(1, 0, 0, 1, "tickld_c1", 1, 0, 1, 1, 0, 2);
        cyc(1, 1, 5, 1, "back5_c0", 0, 1, 1, 1, 0, 5);
        cyc(1, 0, 0, 1, "back5_c1", 0, 1, 1, 1, 0, 5);
        cyc(1, 0, 0, 1, "back5_c2", 0, 1, 1, 1, 0, 5);

        // en dropped at cnt=2: period completes, then idle
        cyc(0, 0, 0, 1, "stop_c3",   0, 0, 1, 1, 0, 5);
        cyc(0, 0, 0, 1, "stop_c4",   1, 0, 1, 1, 0, 5);
        cyc(0, 0, 0, 1, "stop_idle", 0, 0, 0, 1, 0, 5);

        // configure N=2 in idle, then run
        cyc(0, 1, 2, 1, "idle_cfg2", 0, 0, 0, 1, 0, 2);
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 2; k++)
                cyc(1, 0, 0, 1, "n2_run", T2[1-k], L2[1-k], 1, 1, 0, 2);

        // reset while a divisor of 9 is pending
        cyc(1, 1, 5, 1, "rp_c0",   0, 1, 1, 1, 0, 5);
        cyc(1, 0, 0, 1, "rp_c1",   0, 1, 1, 1, 0, 5);
        cyc(1, 1, 9, 1, "rp_pend", 0, 1, 1, 0, 0, 5);
        cyc(1, 0, 0, 0, "rp_rst",  0, 0, 0, 1, 0, 5);
        cyc(0, 0, 0, 1, "rp_idle", 0, 0, 0, 1, 0, 5);

        // en and cfg together in idle; en falls on the tick
        cyc(1, 1, 3, 1, "s3_c0",   0, 1, 1, 1, 0, 3);
        cyc(1, 0, 0, 1, "s3_c1",   0, 1, 1, 1, 0, 3);
        cyc(1, 0, 0, 1, "s3_c2",   1, 0, 1, 1, 0, 3);
        cyc(0, 0, 0, 1, "s3_stop", 0, 0, 0, 1, 0, 3);

        cyc(0, 1, 0, 1, "idle_ill",   0, 0, 0, 1, 1, 3);
        cyc(0, 0, 0, 1, "idle_after", 0, 0, 0, 1, 0, 3);

        // stop from PEND still applies the pending divisor
        cyc(1, 0, 0, 1, "sp_c0",   0, 1, 1, 1, 0, 3);
        cyc(0, 1, 4, 1, "sp_c1",   0, 1, 1, 0, 0, 3);
        cyc(0, 0, 0, 1, "sp_c2",   1, 0, 1, 0, 0, 3);
        cyc(0, 0, 0, 1, "sp_idle", 0, 0, 0, 1, 0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Single-clock-domain divider controller that schedules and reconfigures a programmable divide-by-N clock-enable generator. It produces a one-cycle period tick and a near-50% duty level output for any divisor N from 2 to 2^CNT_W-1. Divisor changes arrive over a valid/ready handshake and take effect only at a period boundary, so no truncated or stretched periods ever appear downstream. It sits between the configuration/CSR path and the divided-clock consumers that the odd-ratio dividers feed.

## Interface
- CNT_W, 8, width of divisor and period counter
- DEF_DIV, 5, divisor loaded at reset; must be ≥2 and < 2^CNT_W
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  level; run request
- cfg_valid  in  1  new divisor offered
- cfg_div  in  CNT_W  offered divisor N
- cfg_ready  out  1  controller can accept a divisor
- cfg_err  out  1  one-cycle pulse: accepted divisor was illegal (N<2), discarded
- div_tick  out  1  high during last cycle of each period
- div_level  out  1  divided level, high for first ceil(N/2) cycles of period
- running  out  1  controller in RUN or PEND
- cur_div  out  CNT_W  divisor currently in force

## Operation
- States: IDLE, RUN, PEND (RUN with a divisor waiting for the boundary).
- Registers: state, cnt[CNT_W-1:0], cur_div, pend_div, cfg_err.
- Reset (rst=0 at a rising edge): state=IDLE, cnt=0, cur_div=DEF_DIV, pend_div=0. Any pending divisor is discarded. Outputs: cfg_ready=1, cfg_err=0, div_tick=0, div_level=0, running=0, cur_div=DEF_DIV.
- cfg_ready = (state != PEND). A divisor is accepted on a cycle with cfg_valid && cfg_ready.
- Illegal divisor (cfg_div<2): cfg_err=1 in the next cycle. No state or divisor change.
- IDLE
  - A legal accept loads cur_div next cycle.
  - en=1 moves to RUN next cycle with cnt=0.
  - cnt holds at 0. div_tick=0, div_level=0.
- RUN
  - cnt increments by 1 each cycle; wraps to 0 after cnt == cur_div-1.
  - div_tick = (cnt == cur_div-1).
  - div_level = (cnt < cur_div - (cur_div>>1)).
  - A legal accept on a non-tick cycle stores pend_div and moves to PEND.
  - A legal accept on a tick cycle loads cur_div directly for the next period; state stays RUN.
- PEND
  - Counting as in RUN with the old cur_div.
  - On the tick cycle: cur_div<=pend_div, cnt<=0, return to RUN.
- Stop: with en=0 in RUN or PEND, the current period completes. On its tick cycle the controller goes to IDLE with cnt=0, and a pending divisor is still applied.
- Arithmetic: cur_div-1 and cur_div>>1 are computed in CNT_W bits. N≥2 guarantees no underflow.

## Timing
- en sampled high in IDLE at edge t: running=1, cnt=0, div_level=1 from cycle t+1. The first div_tick is in cycle t+N.
- Period is exactly cur_div cycles. The new divisor governs the cycle right after the tick on which it is applied.
- Config latency:
  - IDLE: cur_div updates 1 cycle after accept.
  - RUN: cur_div updates at the end of the current period, worst case N cycles.
- Simultaneous events:
  - en falling and tick in the same cycle gives IDLE next cycle.
  - en=1 with a cfg accept in IDLE gives RUN with the new divisor in force from the first period.
  - An illegal accept in RUN leaves the state in RUN.
- N=2: div_level alternates 1,0; div_tick every 2nd cycle.
- Reset mid-period aborts immediately. div_tick and div_level are 0 in the cycle after reset.

## Test plan
- Reset, then en=1 with DEF_DIV=5: div_level pattern 1,1,1,0,0 repeating, div_tick on every 5th cycle, cur_div=5, running=1.
- In IDLE, offer cfg_div=2 then en=1: div_level toggles 1,0, div_tick every 2 cycles, cfg_ready stays 1 throughout.
- In RUN with N=5 at cnt=1, offer cfg_div=7:
  - cfg_ready drops next cycle and stays low until the tick.
  - The old period completes at 5 cycles.
  - The next period is 7 cycles with div_level high for 4.
- Offer cfg_div=1 and cfg_div=0 in RUN: cfg_err pulses one cycle each, cur_div unchanged, period unaffected.
- Drop en at cnt=2 of N=5: two more cycles, div_tick on cnt=4, then IDLE, running=0, div_level=0.
- Assert rst=0 for one cycle in PEND with pend_div=9: cur_div returns to DEF_DIV, state IDLE, pending discarded, cfg_ready=1.
